ripple_count_capture: RTL and testbench

//  Downstream consumer of the T-FF ripple counter. Synchronises the counter's asynchronous,

---
 rtl/ripple_count_capture_pkg.sv | 21 ++
 rtl/ripple_count_capture_if.sv | 37 +++
 rtl/ripple_count_capture_sync_2ff.sv | 21 ++
 rtl/ripple_count_capture.sv | 126 ++++++++++++
 tb/tb_ripple_count_capture.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/ripple_count_capture_pkg.sv
// Shared types and constants for the ripple counter capture block.
// State encoding, default sizing and the counter-width helper live here.
package ripple_cap_pkg;

   localparam int         DEF_WIDTH         = 4;
   localparam int         DEF_STABLE_CYCLES = 3;
   localparam int         DEF_TIMEOUT       = 15;
   localparam logic [3:0] DEF_TC_VALUE      = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   // Bits needed to hold 0..max_val inclusive.
   function automatic int cnt_w(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/ripple_count_capture_if.sv
// Handshake bundle between the ripple counter, the capture block and its consumer.
// count_delta and its modport entries exist only with RIPPLE_CAP_DELTA_EN.
interface ripple_count_capture_if #(parameter int WIDTH = 4);

   logic [WIDTH-1:0] ripple_q;
   logic             sample_req;
   logic             out_ready;
   logic [WIDTH-1:0] count_out;
   logic             count_valid;
   logic             count_tc;
   logic             timeout_err;
   logic             busy;
`ifdef RIPPLE_CAP_DELTA_EN
   logic [WIDTH-1:0] count_delta;

   modport slave (
      input  ripple_q, sample_req, out_ready,
      output count_out, count_valid, count_tc, timeout_err, busy, count_delta
   );

   modport master (
      output ripple_q, sample_req, out_ready,
      input  count_out, count_valid, count_tc, timeout_err, busy, count_delta
   );
`else
   modport slave (
      input  ripple_q, sample_req, out_ready,
      output count_out, count_valid, count_tc, timeout_err, busy
   );

   modport master (
      output ripple_q, sample_req, out_ready,
      input  count_out, count_valid, count_tc, timeout_err, busy
   );
`endif

endinterface

// File: rtl/ripple_count_capture_sync_2ff.sv
// Single-bit two-flop synchroniser with asynchronous active-high reset.
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/ripple_count_capture.sv
// Captures one settled sample of an asynchronous ripple counter per request.
// Optional feature: RIPPLE_CAP_DELTA_EN adds count_delta against the previous handshake.
module ripple_count_capture
   import ripple_cap_pkg::*;
#(
   parameter int               WIDTH         = DEF_WIDTH,
   parameter int               STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int               TIMEOUT       = DEF_TIMEOUT,
   parameter logic [WIDTH-1:0] TC_VALUE      = WIDTH'(DEF_TC_VALUE)
) (
   input  logic                   clk,
   input  logic                   reset,
   ripple_count_capture_if.slave  bus
);

   localparam int CW = cnt_w(TIMEOUT);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sync_q, sync_prev;
   logic [CW-1:0]    stable_q, stable_d, stable_inc;
   logic [CW-1:0]    wait_q, wait_d, wait_inc;
   logic             cap, cap_tmo, hs;
   logic [WIDTH-1:0] cnt_q;
   logic             tc_q, tmo_q, vld_q;

   for (genvar g = 0; g < WIDTH; g++) begin : g_sync
      sync_2ff u_sync (
         .clk   (clk),
         .reset (reset),
         .d     (bus.ripple_q[g]),
         .q     (sync_q[g])
      );
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) sync_prev <= '0;
      else       sync_prev <= sync_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         stable_q <= '0;
         wait_q   <= '0;
      end else begin
         state_q  <= state_d;
         stable_q <= stable_d;
         wait_q   <= wait_d;
      end
   end

   // Stable capture is tested first so it wins when both limits land on one edge.
   always_comb begin
      state_d    = state_q;
      stable_d   = stable_q;
      wait_d     = wait_q;
      cap        = 1'b0;
      cap_tmo    = 1'b0;
      hs         = 1'b0;
      stable_inc = (sync_q == sync_prev) ? stable_q + CW'(1) : '0;
      wait_inc   = wait_q + CW'(1);
      case (state_q)
         ST_IDLE: begin
            if (bus.sample_req) begin
               state_d  = ST_SETTLE;
               stable_d = '0;
               wait_d   = '0;
            end
         end
         ST_SETTLE: begin
            stable_d = stable_inc;
            wait_d   = wait_inc;
            if (stable_inc == CW'(STABLE_CYCLES)) begin
               cap     = 1'b1;
               state_d = ST_HOLD;
            end else if (wait_inc == CW'(TIMEOUT)) begin
               cap     = 1'b1;
               cap_tmo = 1'b1;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (bus.out_ready) begin
               hs      = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
         tc_q  <= 1'b0;
         tmo_q <= 1'b0;
         vld_q <= 1'b0;
      end else if (cap) begin
         cnt_q <= sync_q;
         tc_q  <= (sync_q == TC_VALUE);
         tmo_q <= cap_tmo;
         vld_q <= 1'b1;
      end else if (hs) begin
         vld_q <= 1'b0;
      end
   end

   assign bus.count_out   = cnt_q;
   assign bus.count_valid = vld_q;
   assign bus.count_tc    = vld_q & tc_q;
   assign bus.timeout_err = vld_q & tmo_q;
   assign bus.busy        = (state_q != ST_IDLE);

`ifdef RIPPLE_CAP_DELTA_EN
   logic [WIDTH-1:0] last_cap;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)   last_cap <= '0;
      else if (hs) last_cap <= cnt_q;
   end

   // Unsigned modulo-2^WIDTH difference; wraps naturally in WIDTH bits.
   assign bus.count_delta = vld_q ? (cnt_q - last_cap) : '0;
`endif

endmodule

// File: tb/tb_ripple_count_capture.sv
// Scoreboard bench for ripple_count_capture: stimulus pushes expectations, monitor checks
// each new capture. Build with RIPPLE_CAP_DELTA_EN to also check count_delta.
module tb_ripple_count_capture;

   typedef struct {
      logic [3:0] out;
      logic [3:0] alt;
      logic       tc;
      logic       tmo;
      logic [3:0] prev;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad = 0;
   exp_t sb[$];
   bit   seen = 0;

   ripple_count_capture_if #(.WIDTH(4)) bus ();

   ripple_count_capture dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compare each fresh capture against the head of the scoreboard.
   always @(negedge clk) begin
      exp_t       e;
      logic [3:0] sel;
      if (reset) seen = 0;
      else if (bus.count_valid && !seen) begin
         seen = 1;
         if (sb.size() == 0) chk("sb_unexpected", 1, 0);
         else begin
            e   = sb.pop_front();
            sel = (bus.count_out == e.alt) ? e.alt : e.out;
            chk("cap_out", bus.count_out, sel);
            chk("cap_tc", bus.count_tc, e.tc);
            chk("cap_tmo", bus.timeout_err, e.tmo);
`ifdef RIPPLE_CAP_DELTA_EN
            chk("cap_delta", bus.count_delta, 4'(sel - e.prev));
`endif
         end
      end else if (!bus.count_valid) seen = 0;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input logic [3:0] o, input logic [3:0] a, input logic tc,
                       input logic tmo, input logic [3:0] p);
      exp_t e;
      e.out = o; e.alt = a; e.tc = tc; e.tmo = tmo; e.prev = p;
      sb.push_back(e);
   endtask

   task automatic req();
      bus.sample_req = 1'b1;
      tick(1);
      bus.sample_req = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      for (int i = 0; i < 40 && !bus.count_valid; i++) tick(1);
      chk(name, bus.count_valid, 1);
   endtask

   task automatic handshake(input string name);
      bus.out_ready = 1'b1;
      tick(1);
      bus.out_ready = 1'b0;
      chk({name, "_vld_drop"}, bus.count_valid, 0);
      chk({name, "_busy_drop"}, bus.busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.ripple_q   = 4'h5;
      bus.sample_req = 1'b0;
      bus.out_ready  = 1'b0;
      tick(3);
      chk("rst_busy", bus.busy, 0);
      chk("rst_vld", bus.count_valid, 0);
      chk("rst_out", bus.count_out, 0);
      chk("rst_tc", bus.count_tc, 0);
      chk("rst_tmo", bus.timeout_err, 0);
      reset = 1'b0;
      tick(4);

      // Static 5: valid exactly after edge N+3
      push(4'h5, 4'h5, 0, 0, 4'h0);
      req();
      tick(2);
      chk("t1_vld_n2", bus.count_valid, 0);
      tick(1);
      chk("t1_vld_n3", bus.count_valid, 1);
      chk("t1_busy", bus.busy, 1);
      handshake("t1");

      // Terminal count
      bus.ripple_q = 4'hF;
      tick(4);
      push(4'hF, 4'hF, 1, 0, 4'h5);
      req();
      wait_valid("t2_vld");
      handshake("t2");

      // Frozen in HOLD, extra requests ignored
      bus.ripple_q = 4'h9;
      tick(4);
      push(4'h9, 4'h9, 0, 0, 4'hF);
      req();
      wait_valid("t4_vld");
      for (int i = 0; i < 10; i++) begin
         bus.ripple_q   = 4'(i);
         bus.sample_req = (i % 2 == 1);
         tick(1);
         chk("t4_frozen", bus.count_out, 4'h9);
         chk("t4_held", bus.count_valid, 1);
      end
      bus.sample_req = 1'b0;
      handshake("t4");
      tick(4);
      chk("t4_noqueue", bus.busy, 0);

      // Toggling 3<->4 forces a timeout capture at edge N+15
      bus.ripple_q = 4'h3;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         bus.ripple_q = (bus.ripple_q == 4'h3) ? 4'h4 : 4'h3;
      end
      push(4'h3, 4'h4, 0, 1, 4'h9);
      bus.sample_req = 1'b1;
      tick(1);
      bus.sample_req = 1'b0;
      bus.ripple_q = (bus.ripple_q == 4'h3) ? 4'h4 : 4'h3;
      for (int k = 1; k <= 15; k++) begin
         tick(1);
         bus.ripple_q = (bus.ripple_q == 4'h3) ? 4'h4 : 4'h3;
         if (k == 14) chk("t3_vld_n14", bus.count_valid, 0);
         if (k == 15) chk("t3_vld_n15", bus.count_valid, 1);
      end
      handshake("t3");

      // Async reset mid-SETTLE
      bus.ripple_q = 4'h6;
      tick(4);
      req();
      tick(2);
      chk("t5_busy_settle", bus.busy, 1);
      reset = 1'b1;
      #1;
      chk("t5_rst_busy", bus.busy, 0);
      chk("t5_rst_vld", bus.count_valid, 0);
      tick(2);
      reset = 1'b0;
      tick(4);
      push(4'h6, 4'h6, 0, 0, 4'h0);
      req();
      wait_valid("t5_vld");
      handshake("t5");

      // Delta wrap: E then 2 gives 4
      bus.ripple_q = 4'hE;
      tick(4);
      push(4'hE, 4'hE, 0, 0, 4'h6);
      req();
      wait_valid("t6a_vld");
      handshake("t6a");
      bus.ripple_q = 4'h2;
      tick(4);
      push(4'h2, 4'h2, 0, 0, 4'hE);
      req();
      wait_valid("t6b_vld");
      handshake("t6b");

      tick(2);
      chk("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
